// File: rtl/res50_pkg.sv
// Shared definitions for the res50 layer scheduler: state encoding and the
// packed layer-descriptor layout.
package res50_pkg;

    localparam int W_SIZE_DEF   = 8;
    localparam int W_DELAY_DEF  = 12;
    localparam int N_LAYERS_DEF = 16;
    localparam int W_LADDR_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DRAIN = 3'd5
    } sched_state_t;

    // Descriptor fields, listed LSB first.
    typedef enum logic [2:0] {
        FLD_FRAME_SIZE = 3'd0,
        FLD_HSYNC      = 3'd1,
        FLD_VSYNC      = 3'd2,
        FLD_STEP_Y     = 3'd3,
        FLD_STEP_X     = 3'd4,
        FLD_CHANNEL    = 3'd5,
        FLD_HEIGHT     = 3'd6,
        FLD_WIDTH      = 3'd7
    } desc_fld_t;

    function automatic int frame_size_w(input int w_size);
        return 2 * w_size + 3;
    endfunction

    function automatic int desc_w(input int w_size, input int w_delay, input int w_frame);
        return 5 * w_size + 2 * w_delay + w_frame;
    endfunction

    function automatic int desc_off(input desc_fld_t f, input int w_size,
                                    input int w_delay, input int w_frame);
        case (f)
            FLD_FRAME_SIZE: return 0;
            FLD_HSYNC:      return w_frame;
            FLD_VSYNC:      return w_frame + w_delay;
            FLD_STEP_Y:     return w_frame + 2 * w_delay;
            FLD_STEP_X:     return w_frame + 2 * w_delay + w_size;
            FLD_CHANNEL:    return w_frame + 2 * w_delay + 2 * w_size;
            FLD_HEIGHT:     return w_frame + 2 * w_delay + 3 * w_size;
            FLD_WIDTH:      return w_frame + 2 * w_delay + 4 * w_size;
            default:        return 0;
        endcase
    endfunction

    function automatic int desc_fld_w(input desc_fld_t f, input int w_size,
                                      input int w_delay, input int w_frame);
        case (f)
            FLD_FRAME_SIZE:        return w_frame;
            FLD_HSYNC, FLD_VSYNC:  return w_delay;
            default:               return w_size;
        endcase
    endfunction

    localparam int W_DESC_DEF = desc_w(W_SIZE_DEF, W_DELAY_DEF, frame_size_w(W_SIZE_DEF));

endpackage

// File: rtl/res50_desc_ram.sv
// Layer descriptor table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module res50_desc_ram #(
    parameter int N_LAYERS = 16,
    parameter int W_LADDR  = 4,
    parameter int W_DESC   = 83
) (
    input  logic              clk,
    input  logic              we,
    input  logic [W_LADDR-1:0] waddr,
    input  logic [W_DESC-1:0]  wdata,
    input  logic [W_LADDR-1:0] raddr,
    output logic [W_DESC-1:0]  rdata
);

    logic [W_DESC-1:0] mem [N_LAYERS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/res50_layer_sched.sv
// Sequences res50_fsm over a programmed list of layers: load descriptor,
// pulse start, wait for the last beat of the frame, idle for a gap, repeat.
module res50_layer_sched
    import res50_pkg::*;
#(
    parameter int W_SIZE       = W_SIZE_DEF,
    parameter int W_FRAME_SIZE = frame_size_w(W_SIZE),
    parameter int W_DELAY      = W_DELAY_DEF,
    parameter int N_LAYERS     = N_LAYERS_DEF,
    parameter int W_LADDR      = W_LADDR_DEF,
    parameter int W_DESC       = desc_w(W_SIZE, W_DELAY, W_FRAME_SIZE)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_cfg_we,
    input  logic [W_LADDR-1:0]      i_cfg_addr,
    input  logic [W_DESC-1:0]       i_cfg_wdata,
    input  logic                    i_run,
    input  logic [W_LADDR:0]        i_num_layers,
    input  logic [W_DELAY-1:0]      i_gap,
    input  logic                    i_abort,
    input  logic                    i_ctrl_data_run,
    input  logic                    i_end_frame,
    output logic [W_SIZE-1:0]       q_width,
    output logic [W_SIZE-1:0]       q_height,
    output logic [W_SIZE-1:0]       q_channel,
    output logic [W_SIZE-1:0]       q_step_x,
    output logic [W_SIZE-1:0]       q_step_y,
    output logic [W_DELAY-1:0]      q_vsync_delay,
    output logic [W_DELAY-1:0]      q_hsync_delay,
    output logic [W_FRAME_SIZE-1:0] q_frame_size,
    output logic                    q_start,
    output logic                    o_busy,
    output logic [W_LADDR-1:0]      o_cur_layer,
    output logic                    o_layer_done,
    output logic                    o_seq_done,
    output logic                    o_aborted,
    output logic                    o_cfg_err
);

    localparam int OFF_WIDTH   = desc_off(FLD_WIDTH,      W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_HEIGHT  = desc_off(FLD_HEIGHT,     W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_CHANNEL = desc_off(FLD_CHANNEL,    W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_STEP_X  = desc_off(FLD_STEP_X,     W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_STEP_Y  = desc_off(FLD_STEP_Y,     W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_VSYNC   = desc_off(FLD_VSYNC,      W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_HSYNC   = desc_off(FLD_HSYNC,      W_SIZE, W_DELAY, W_FRAME_SIZE);
    localparam int OFF_FRAME   = desc_off(FLD_FRAME_SIZE, W_SIZE, W_DELAY, W_FRAME_SIZE);

    localparam logic [W_LADDR:0]   ONE_L = (W_LADDR+1)'(1);
    localparam logic [W_LADDR:0]   N_MAX = (W_LADDR+1)'(N_LAYERS);
    localparam logic [W_DELAY-1:0] ONE_G = W_DELAY'(1);

    sched_state_t       state, state_nx;
    logic [W_LADDR:0]   layer, num_layers, run_n;
    logic [W_DELAY-1:0] gap, gap_cnt;
    logic               abort_flag;
    logic [W_DESC-1:0]  rd_desc;
    logic               frame_end, last_layer, tbl_we;
    logic               do_run, do_load, layer_inc, gap_clr, gap_inc, set_abort, clr_abort;
    logic               layer_done_nx, seq_done_nx, aborted_nx;

    // Only the last beat of the fsm counts; end_frame alone may be a stalled beat.
    assign frame_end  = i_end_frame & i_ctrl_data_run;
    assign last_layer = (layer == num_layers - ONE_L);
    assign run_n      = (i_num_layers > N_MAX) ? N_MAX : i_num_layers;
    assign tbl_we     = i_cfg_we && (state == ST_IDLE);

    res50_desc_ram #(
        .N_LAYERS (N_LAYERS),
        .W_LADDR  (W_LADDR),
        .W_DESC   (W_DESC)
    ) u_desc_ram (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (i_cfg_addr),
        .wdata (i_cfg_wdata),
        .raddr (layer[W_LADDR-1:0]),
        .rdata (rd_desc)
    );

    always_comb begin
        state_nx      = state;
        do_run        = 1'b0;
        do_load       = 1'b0;
        layer_inc     = 1'b0;
        gap_clr       = 1'b0;
        gap_inc       = 1'b0;
        set_abort     = 1'b0;
        clr_abort     = 1'b0;
        layer_done_nx = 1'b0;
        seq_done_nx   = 1'b0;
        aborted_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_run) begin
                    if (run_n == '0) begin
                        seq_done_nx = 1'b1;
                    end else begin
                        do_run    = 1'b1;
                        clr_abort = 1'b1;
                        state_nx  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                do_load   = 1'b1;
                set_abort = i_abort;
                state_nx  = ST_START;
            end
            ST_START: begin
                set_abort = i_abort;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                // A frame end in the same cycle as an abort completes the layer first;
                // the abort is then taken from GAP.
                if (frame_end) begin
                    layer_done_nx = 1'b1;
                    set_abort     = i_abort;
                    if (last_layer) begin
                        seq_done_nx = 1'b1;
                        clr_abort   = 1'b1;
                        state_nx    = ST_IDLE;
                    end else begin
                        layer_inc = 1'b1;
                        gap_clr   = 1'b1;
                        state_nx  = ST_GAP;
                    end
                end else if (i_abort || abort_flag) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (i_abort || abort_flag) begin
                    aborted_nx = 1'b1;
                    clr_abort  = 1'b1;
                    state_nx   = ST_IDLE;
                end else if (gap_cnt == gap) begin
                    state_nx = ST_LOAD;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (frame_end) begin
                    layer_done_nx = 1'b1;
                    aborted_nx    = 1'b1;
                    clr_abort     = 1'b1;
                    state_nx      = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            layer         <= '0;
            num_layers    <= '0;
            gap           <= '0;
            gap_cnt       <= '0;
            abort_flag    <= 1'b0;
            o_layer_done  <= 1'b0;
            o_seq_done    <= 1'b0;
            o_aborted     <= 1'b0;
            o_cfg_err     <= 1'b0;
            q_width       <= '0;
            q_height      <= '0;
            q_channel     <= '0;
            q_step_x      <= '0;
            q_step_y      <= '0;
            q_vsync_delay <= '0;
            q_hsync_delay <= '0;
            q_frame_size  <= '0;
        end else begin
            state        <= state_nx;
            o_layer_done <= layer_done_nx;
            o_seq_done   <= seq_done_nx;
            o_aborted    <= aborted_nx;
            o_cfg_err    <= i_cfg_we && (state != ST_IDLE);

            if (do_run) begin
                num_layers <= run_n;
                gap        <= i_gap;
                layer      <= '0;
            end else if (layer_inc) begin
                layer <= layer + ONE_L;
            end

            if (gap_clr)      gap_cnt <= '0;
            else if (gap_inc) gap_cnt <= gap_cnt + ONE_G;

            if (clr_abort)      abort_flag <= 1'b0;
            else if (set_abort) abort_flag <= 1'b1;

            if (do_load) begin
                q_width       <= rd_desc[OFF_WIDTH   +: W_SIZE];
                q_height      <= rd_desc[OFF_HEIGHT  +: W_SIZE];
                q_channel     <= rd_desc[OFF_CHANNEL +: W_SIZE];
                q_step_x      <= rd_desc[OFF_STEP_X  +: W_SIZE];
                q_step_y      <= rd_desc[OFF_STEP_Y  +: W_SIZE];
                q_vsync_delay <= rd_desc[OFF_VSYNC   +: W_DELAY];
                q_hsync_delay <= rd_desc[OFF_HSYNC   +: W_DELAY];
                q_frame_size  <= rd_desc[OFF_FRAME   +: W_FRAME_SIZE];
            end
        end
    end

    assign q_start     = (state == ST_START);
    assign o_busy      = (state != ST_IDLE);
    assign o_cur_layer = layer[W_LADDR-1:0];

endmodule
